// File: rtl/multi_filter_frame_receptor.sv
// Frame receiver: NUM_FILTERS destination-MAC filters, payload checksum, inter-frame gap, Avalon-MM config.
// Define FRAME_RECEPTOR_STATS_EN to build the accept/drop/runt counters and the clear-counters bit.
module multi_filter_frame_receptor #(
  parameter int DATA_W      = 16,
  parameter int NUM_FILTERS = 4,
  parameter int PRE_BYTES   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        writedata,
  input  logic              write,
  input  logic              chipselect,
  input  logic [7:0]        address,
  input  logic              read,
  output logic [7:0]        readdata,
  input  logic [DATA_W-1:0] ingress_port_tdata,
  input  logic              ingress_port_tvalid,
  output logic              ingress_port_tready,
  input  logic              ingress_port_tlast
);
  localparam int B         = DATA_W / 8;
  localparam int PRE_BEATS = PRE_BYTES / B;
  localparam int DST_BEATS = 6 / B;
  localparam int HDR_BEATS = 8 / B;

  // state | meaning
  // IDLE wait for frame | PRE skip preamble | DST match MAC | HDR skip src+type | PAY sum payload | GAP hold off
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DST, S_HDR, S_PAY, S_GAP} state_t;
  localparam state_t FIRST_PH = (PRE_BEATS == 0) ? S_DST : S_PRE;

  state_t                 state_q, beat_ph, next_ph;
  logic [7:0]             cnt_q, beat_cnt, phase_len;
  logic [NUM_FILTERS-1:0] hit_q, en_q, hit_base, byte_hit;
  logic [31:0]            acc_q, csum_q, pay_sum;
  logic [7:0]             status_q, gap_q, ifg_q, rd_d, readdata_q;
  logic                   prom_q, matched, xfer, wr, fsel;
  logic [2:0]             hit_idx;
  logic [3:0]             fk;
  logic [47:0]            mac_q [NUM_FILTERS];

  assign ingress_port_tready = (state_q != S_GAP) && !reset;
  assign xfer     = ingress_port_tvalid && ingress_port_tready;
  assign wr       = chipselect && write;
  assign readdata = readdata_q;
  assign pay_sum  = acc_q + 32'(ingress_port_tdata);
  assign matched  = (|hit_q) || prom_q;
  assign hit_base = (state_q == S_IDLE) ? en_q : hit_q;
  assign fk       = address[6:3] - 4'd2;
  assign fsel     = !address[7] && (address[6:3] >= 4'd2) && (fk < 4'(NUM_FILTERS));

  // The beat accepted in IDLE is already the first beat of the preamble.
  always_comb begin
    beat_ph   = state_q;
    beat_cnt  = cnt_q;
    if (state_q == S_IDLE) begin
      beat_ph  = FIRST_PH;
      beat_cnt = '0;
    end
    phase_len = 8'd0;
    next_ph   = S_PAY;
    case (beat_ph)
      S_PRE:   begin phase_len = 8'(PRE_BEATS); next_ph = S_DST; end
      S_DST:   begin phase_len = 8'(DST_BEATS); next_ph = S_HDR; end
      S_HDR:   begin phase_len = 8'(HDR_BEATS); next_ph = S_PAY; end
      default: ;
    endcase
  end

  always_comb begin
    byte_hit = '1;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      for (int b = 0; b < B; b++) begin
        if (((int'(beat_cnt) * B + b) < 6) &&
            (mac_q[k][(int'(beat_cnt) * B + b) * 8 +: 8] != ingress_port_tdata[b * 8 +: 8]))
          byte_hit[k] = 1'b0;
      end
    end
  end

  always_comb begin
    hit_idx = '0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      if (hit_q[k]) hit_idx = 3'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hit_q    <= '0;
      acc_q    <= '0;
      csum_q   <= '0;
      status_q <= '0;
      gap_q    <= '0;
    end else if (state_q == S_GAP) begin
      if (gap_q <= 8'd1) state_q <= S_IDLE;
      else               gap_q   <= gap_q - 8'd1;
    end else if (xfer) begin
      acc_q <= (state_q == S_IDLE) ? '0 : ((beat_ph == S_PAY) ? pay_sum : acc_q);
      hit_q <= (beat_ph == S_DST) ? (hit_base & byte_hit) : hit_base;
      cnt_q <= '0;
      if (ingress_port_tlast) begin
        state_q <= (ifg_q != 8'd0) ? S_GAP : S_IDLE;
        gap_q   <= ifg_q;
        if (beat_ph == S_PAY) begin
          csum_q   <= pay_sum;
          status_q <= {1'b0, hit_idx, 3'b000, matched};
        end else begin
          status_q <= 8'h02;
        end
      end else if (beat_ph == S_PAY) begin
        state_q <= S_PAY;
      end else if (beat_cnt == phase_len - 8'd1) begin
        state_q <= next_ph;
      end else begin
        state_q <= beat_ph;
        cnt_q   <= beat_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prom_q <= 1'b0;
      ifg_q  <= '0;
      en_q   <= '0;
      for (int k = 0; k < NUM_FILTERS; k++) mac_q[k] <= '0;
    end else if (wr) begin
      if (address == 8'h00) prom_q <= writedata[0];
      if (address == 8'h01) ifg_q  <= writedata;
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (fsel && (fk == 4'(k))) begin
          if (address[2:0] < 3'd6)       mac_q[k][int'(address[2:0]) * 8 +: 8] <= writedata;
          else if (address[2:0] == 3'd6) en_q[k] <= writedata[0];
        end
      end
    end
  end

`ifdef FRAME_RECEPTOR_STATS_EN
  logic [15:0] acc_cnt_q, drop_cnt_q, runt_cnt_q;
  logic        clr;
  assign clr = wr && (address == 8'h00) && writedata[1];

  // A clear on the same edge as an increment wins.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
      runt_cnt_q <= '0;
    end else if (xfer && ingress_port_tlast) begin
      if (beat_ph != S_PAY) begin
        if (runt_cnt_q != 16'hFFFF) runt_cnt_q <= runt_cnt_q + 16'd1;
      end else if (matched) begin
        if (acc_cnt_q != 16'hFFFF)  acc_cnt_q  <= acc_cnt_q + 16'd1;
      end else begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end
`endif

  always_comb begin
    rd_d = '0;
    case (address)
      8'h00: rd_d = {7'b0, prom_q};
      8'h01: rd_d = ifg_q;
      8'h02: rd_d = status_q;
      8'h04: rd_d = csum_q[7:0];
      8'h05: rd_d = csum_q[15:8];
      8'h06: rd_d = csum_q[23:16];
      8'h07: rd_d = csum_q[31:24];
`ifdef FRAME_RECEPTOR_STATS_EN
      8'h08: rd_d = acc_cnt_q[7:0];
      8'h09: rd_d = acc_cnt_q[15:8];
      8'h0A: rd_d = drop_cnt_q[7:0];
      8'h0B: rd_d = drop_cnt_q[15:8];
      8'h0C: rd_d = runt_cnt_q[7:0];
      8'h0D: rd_d = runt_cnt_q[15:8];
`endif
      default: ;
    endcase
    for (int k = 0; k < NUM_FILTERS; k++) begin
      if (fsel && (fk == 4'(k))) begin
        if (address[2:0] < 3'd6)       rd_d = mac_q[k][int'(address[2:0]) * 8 +: 8];
        else if (address[2:0] == 3'd6) rd_d = {7'b0, en_q[k]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= (chipselect && read) ? rd_d : 8'h00;
  end
endmodule
